mips_mult_pipe: RTL and testbench
=================================

Name: mips_mult_pipe

Overview:
Pipelined 32x32 integer multiplier unit that executes MULT/MULTU issued from Decode. It sits beside the hazard/stall logic: the stall logic tracks the multiplier's P0..P3/W occupancy, and this block does the arithmetic along the same stage timeline. It drives the dedicated multiplier write-back into the register file and the HI/LO pair. It is free-running: a new operation may launch every cycle, and in-flight operations never freeze.

Parameters:
DATA_W, 32, operand width (must be even; split into halves of DATA_W/2)
REG_ADDR_W, 5, register address width (from mips_pkg)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mult_start_D  in  1  Decode holds a multiply instruction
stall  in  1  pipeline stall from the stall generator; blocks launch
mult_signed_D  in  1  1 = MULT (two's complement), 0 = MULTU
src_a_data_D  in  DATA_W  operand A read in Decode
src_b_data_D  in  DATA_W  operand B read in Decode
reg_dest_addr_mult  in  REG_ADDR_W  destination register for the multiply result
mult_wb_valid  out  1  result write-back strobe (W stage)
mult_wb_addr  out  REG_ADDR_W  write-back register address
mult_wb_data  out  DATA_W  low DATA_W bits of the product
mult_hi  out  DATA_W  HI register (last completed product, upper half)
mult_lo  out  DATA_W  LO register (last completed product, lower half)
mult_busy  out  1  any of P0..P3 valid

Behaviour:
- Launch: launch_D = mult_start_D & ~stall. Launch is sampled into P0 on the next clock edge.
- Stages: each stage carries valid, dest addr, sign flag and data. They advance every cycle with no back-pressure.
  - P0: register |A| and |B|. When mult_signed_D is 1, take the magnitude of a negative operand. neg = signed & (A[msb]^B[msb]). For MULTU, neg = 0 and operands pass unchanged.
  - P1: four unsigned (DATA_W/2)x(DATA_W/2) partial products: ll, lh, hl, hh, each DATA_W wide.
  - P2: mid = lh + hl, DATA_W+1 bits, carry kept. Pass ll and hh through.
  - P3: prod = {hh,ll} + (mid << DATA_W/2), 2*DATA_W bits. If neg, prod = -prod (two's complement, 2*DATA_W bits).
  - W: register prod, valid and addr.
- Latency: launch in cycle n gives mult_wb_valid = 1 in cycle n+5, for exactly one cycle.
- Throughput: 1 per cycle. Back-to-back launches in n and n+1 produce writes in n+5 and n+6.
- Outputs at W:
  - mult_wb_data = prod[DATA_W-1:0]; mult_wb_addr = the address captured at launch.
  - mult_wb_addr/data are don't-care when mult_wb_valid = 0; they are driven 0 by reset.
- HI/LO: {mult_hi, mult_lo} load prod on the cycle W becomes valid, i.e. they update in cycle n+6. They hold otherwise.
- mult_busy = valid_P0 | valid_P1 | valid_P2 | valid_P3 (combinational from stage valids).
- Stall during launch: if mult_start_D = 1 and stall = 1, nothing enters P0. The same instruction launches once, on the first cycle stall = 0.
- Corner values:
  - MULT 0x80000000 * 0x80000000 = 0x4000000000000000. The magnitude of the min int is 2^31, representable unsigned in DATA_W bits.
  - Any operand 0 with neg = 1 gives product 0 (negating 0 yields 0).
- Reset:
  - All valids, mult_wb_valid, mult_wb_addr, mult_wb_data, mult_hi, mult_lo and mult_busy go to 0.
  - Reset asserted mid-operation discards every in-flight product; no write-back occurs after rst deasserts.
- Address 0: write-back is still strobed; the register file ignores writes to $0.

Decomposition:
- mips_pkg holds: MULT_LAT = 5 and a t_mult_stage struct {valid, dest addr, neg}. REG_ADDR_W already lives there.
- Sub-module mips_mult_pp (combinational 4-way half-width partial-product generator) is instantiated in P1.
- Stage registers use the team's standard reset-FF macro.

Test Plan:
- MULTU 0x0000_0003 * 0x0000_0005 launched cycle 10, dest 8 -> cycle 15: wb_valid = 1, addr = 8, data = 0x0000000F. Cycle 16: hi = 0, lo = 0xF.
- MULT 0xFFFFFFFF(-1) * 0x00000007 -> data = 0xFFFFFFF9, hi = 0xFFFFFFFF. The same operands as MULTU give hi = 0x00000006, lo = 0xFFFFFFF9.
- MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0x00000000. MULT 0x80000000 * 0 -> 0.
- Launches in 4 consecutive cycles with dests 1, 2, 3, 4 -> 4 consecutive write-backs in order with correct products; mult_busy high for cycles n+1..n+7.
- mult_start_D = 1 with stall = 1 for 3 cycles, then stall = 0 -> exactly one write-back, 5 cycles after the release cycle.
- Launch, then rst pulse at cycle n+2 -> no mult_wb_valid ever; hi/lo stay 0.
- Random signed/unsigned operands, 10k ops, compared against a 64-bit reference model.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiplier pipeline.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MULT_LAT   = 5;

    // Per-stage control that travels alongside the arithmetic payload
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic                  neg;
    } t_mult_stage;

    localparam t_mult_stage STAGE_IDLE = t_mult_stage'({(REG_ADDR_W + 2){1'b0}});

endpackage

// File: rtl/mips_mult_pipe_if.sv
// Decode-side launch signals and write-back/HI-LO results of the multiplier.
interface mips_mult_pipe_if import mips_pkg::*; #(parameter int DATA_W = 32);

    logic                  mult_start_D;
    logic                  stall;
    logic                  mult_signed_D;
    logic [DATA_W-1:0]     src_a_data_D;
    logic [DATA_W-1:0]     src_b_data_D;
    logic [REG_ADDR_W-1:0] reg_dest_addr_mult;
    logic                  mult_wb_valid;
    logic [REG_ADDR_W-1:0] mult_wb_addr;
    logic [DATA_W-1:0]     mult_wb_data;
    logic [DATA_W-1:0]     mult_hi;
    logic [DATA_W-1:0]     mult_lo;
    logic                  mult_busy;

    modport master (
        output mult_start_D, stall, mult_signed_D, src_a_data_D, src_b_data_D, reg_dest_addr_mult,
        input  mult_wb_valid, mult_wb_addr, mult_wb_data, mult_hi, mult_lo, mult_busy
    );

    modport slave (
        input  mult_start_D, stall, mult_signed_D, src_a_data_D, src_b_data_D, reg_dest_addr_mult,
        output mult_wb_valid, mult_wb_addr, mult_wb_data, mult_hi, mult_lo, mult_busy
    );

endinterface

// File: rtl/mips_mult_pp.sv
// Four half-width unsigned partial products of two magnitude operands.
module mips_mult_pp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic [DATA_W-1:0] ll,
    output logic [DATA_W-1:0] lh,
    output logic [DATA_W-1:0] hl,
    output logic [DATA_W-1:0] hh
);

    localparam int H = DATA_W / 2;

    logic [DATA_W-1:0] a_lo_s, a_hi_s, b_lo_s, b_hi_s;

    // Zero-extend each half so every product is computed at full width
    always_comb begin
        a_lo_s = {{H{1'b0}}, a_mag[H-1:0]};
        a_hi_s = {{H{1'b0}}, a_mag[DATA_W-1:H]};
        b_lo_s = {{H{1'b0}}, b_mag[H-1:0]};
        b_hi_s = {{H{1'b0}}, b_mag[DATA_W-1:H]};
        ll     = a_lo_s * b_lo_s;
        lh     = a_lo_s * b_hi_s;
        hl     = a_hi_s * b_lo_s;
        hh     = a_hi_s * b_hi_s;
    end

endmodule

// File: rtl/mips_mult_pipe.sv
// Free-running five-stage MULT/MULTU unit: P0 magnitudes, P1 partial products,
// P2 middle sum, P3 recombination, W sign fix-up plus write-back and HI/LO.
module mips_mult_pipe import mips_pkg::*; #(
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    mips_mult_pipe_if.slave mif
);

    localparam int H = DATA_W / 2;
    localparam logic [DATA_W-1:0]   ONE_W  = {{(DATA_W - 1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W = {{(2*DATA_W - 1){1'b0}}, 1'b1};

    t_mult_stage         p0_r, p1_r, p2_r, p3_r;
    logic                launch_s, neg_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s, a_mag_r, b_mag_r;
    logic [DATA_W-1:0]   pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
    logic [DATA_W-1:0]   ll_r, lh_r, hl_r, hh_r, p2_ll_r, p2_hh_r;
    logic [DATA_W:0]     mid_r;
    logic [2*DATA_W-1:0] sum_s, sum_r, prod_s, w_prod_r;
    logic                w_valid_r;
    logic [REG_ADDR_W-1:0] w_addr_r;
    logic [DATA_W-1:0]   hi_r, lo_r;

    // Launch qualification and operand magnitudes; the min int maps onto itself as an unsigned 2^(W-1)
    always_comb begin
        launch_s = mif.mult_start_D & ~mif.stall;
        neg_s    = mif.mult_signed_D & (mif.src_a_data_D[DATA_W-1] ^ mif.src_b_data_D[DATA_W-1]);
        if (mif.mult_signed_D & mif.src_a_data_D[DATA_W-1]) begin
            a_mag_s = ~mif.src_a_data_D + ONE_W;
        end else begin
            a_mag_s = mif.src_a_data_D;
        end
        if (mif.mult_signed_D & mif.src_b_data_D[DATA_W-1]) begin
            b_mag_s = ~mif.src_b_data_D + ONE_W;
        end else begin
            b_mag_s = mif.src_b_data_D;
        end
    end

    // P0: capture launch and operand magnitudes
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_r    <= STAGE_IDLE;
            a_mag_r <= {DATA_W{1'b0}};
            b_mag_r <= {DATA_W{1'b0}};
        end else begin
            p0_r    <= '{valid: launch_s, addr: mif.reg_dest_addr_mult, neg: neg_s};
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
        end
    end

    mips_mult_pp #(.DATA_W(DATA_W)) u_pp (
        .a_mag (a_mag_r),
        .b_mag (b_mag_r),
        .ll    (pp_ll_s),
        .lh    (pp_lh_s),
        .hl    (pp_hl_s),
        .hh    (pp_hh_s)
    );

    // P1 and P2: partial products, then the carry-preserving middle sum
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_r    <= STAGE_IDLE;
            p2_r    <= STAGE_IDLE;
            ll_r    <= {DATA_W{1'b0}};
            lh_r    <= {DATA_W{1'b0}};
            hl_r    <= {DATA_W{1'b0}};
            hh_r    <= {DATA_W{1'b0}};
            mid_r   <= {(DATA_W + 1){1'b0}};
            p2_ll_r <= {DATA_W{1'b0}};
            p2_hh_r <= {DATA_W{1'b0}};
        end else begin
            p1_r    <= p0_r;
            p2_r    <= p1_r;
            ll_r    <= pp_ll_s;
            lh_r    <= pp_lh_s;
            hl_r    <= pp_hl_s;
            hh_r    <= pp_hh_s;
            mid_r   <= {1'b0, lh_r} + {1'b0, hl_r};
            p2_ll_r <= ll_r;
            p2_hh_r <= hh_r;
        end
    end

    // Recombine the unsigned product, then restore the sign on the way into W
    always_comb begin
        sum_s = {p2_hh_r, p2_ll_r} + {{(DATA_W - H - 1){1'b0}}, mid_r, {H{1'b0}}};
        if (p3_r.neg) begin
            prod_s = ~sum_r + ONE_2W;
        end else begin
            prod_s = sum_r;
        end
    end

    // P3 and W: recombined magnitude, then the final signed product
    always_ff @(posedge clk) begin
        if (rst) begin
            p3_r      <= STAGE_IDLE;
            sum_r     <= {(2*DATA_W){1'b0}};
            w_valid_r <= 1'b0;
            w_addr_r  <= {REG_ADDR_W{1'b0}};
            w_prod_r  <= {(2*DATA_W){1'b0}};
        end else begin
            p3_r      <= p2_r;
            sum_r     <= sum_s;
            w_valid_r <= p3_r.valid;
            w_addr_r  <= p3_r.addr;
            w_prod_r  <= prod_s;
        end
    end

    // HI/LO take the product one cycle after its write-back strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (w_valid_r) begin
            hi_r <= w_prod_r[2*DATA_W-1:DATA_W];
            lo_r <= w_prod_r[DATA_W-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign mif.mult_wb_valid = w_valid_r;
    assign mif.mult_wb_addr  = w_addr_r;
    assign mif.mult_wb_data  = w_prod_r[DATA_W-1:0];
    assign mif.mult_hi       = hi_r;
    assign mif.mult_lo       = lo_r;
    assign mif.mult_busy     = p0_r.valid | p1_r.valid | p2_r.valid | p3_r.valid;

endmodule

// File: tb/tb_mips_mult_pipe.sv
// Bench for mips_mult_pipe: vector table, launch/stall/reset sequences and
// random traffic, all checked by a cycle-stamped scoreboard at the falling edge.
module tb_mips_mult_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   hilo_cyc = -1;
    logic [63:0] hilo_exp = 64'h0;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [63:0] prod;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[10];

    mips_mult_pipe_if #(.DATA_W(32)) mif ();

    mips_mult_pipe #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (s) r = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        else   r = {32'h0, a} * {32'h0, b};
        return r;
    endfunction

    // Drive one cycle of Decode inputs and record the expected result if it launches
    task automatic drive(input logic start, input logic stl, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        mif.mult_start_D       = start;
        mif.stall              = stl;
        mif.mult_signed_D      = sgn;
        mif.src_a_data_D       = a;
        mif.src_b_data_D       = b;
        mif.reg_dest_addr_mult = d;
        if (start && !stl) sbq.push_back('{due: cyc + 5, addr: d, prod: ref_mul(sgn, a, b)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Scoreboard monitor: write-back timing/content, HI/LO follow-up and busy occupancy
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = 1'b0;
        foreach (sbq[i]) if (sbq[i].due - 4 <= cyc && cyc <= sbq[i].due - 1) exp_busy = 1'b1;
        chk("busy", {63'h0, mif.mult_busy}, {63'h0, exp_busy});
        if (cyc == hilo_cyc) begin
            chk("hi", {32'h0, mif.mult_hi}, {32'h0, hilo_exp[63:32]});
            chk("lo", {32'h0, mif.mult_lo}, {32'h0, hilo_exp[31:0]});
        end
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            nchk++;
            nfail++;
            $display("FAIL missing_wb at cycle %0d: got none, want addr %0d due %0d", cyc, sbq[0].addr, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (mif.mult_wb_valid) begin
            if (sbq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_wb at cycle %0d: got addr %0d data %h, want no write-back",
                         cyc, mif.mult_wb_addr, mif.mult_wb_data);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("wb_cycle", 64'(cyc), 64'(e.due));
                chk("wb_addr", {59'h0, mif.mult_wb_addr}, {59'h0, e.addr});
                chk("wb_data", {32'h0, mif.mult_wb_data}, {32'h0, e.prod[31:0]});
                hilo_exp = e.prod;
                hilo_cyc = cyc + 1;
            end
        end
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 5'd8,  64'h0000_0000_0000_000F};
        tbl[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 5'd9,  64'hFFFF_FFFF_FFFF_FFF9};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0007, 5'd10, 64'h0000_0006_FFFF_FFF9};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 5'd11, 64'h4000_0000_0000_0000};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 5'd12, 64'h0000_0000_0000_0000};
        tbl[5] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 5'd13, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 5'd14, 64'h0000_0000_0000_0000};
        tbl[7] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd15, 64'h3FFF_FFFF_0000_0001};
        tbl[8] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  64'h0000_0000_0000_0001};
        tbl[9] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 64'hFFFF_FFFE_0000_0001};

        mif.mult_start_D = 1'b0;
        mif.stall = 1'b0;
        mif.mult_signed_D = 1'b0;
        mif.src_a_data_D = 32'h0;
        mif.src_b_data_D = 32'h0;
        mif.reg_dest_addr_mult = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {63'h0, mif.mult_wb_valid}, 64'h0);
        chk("rst_wb_addr", {59'h0, mif.mult_wb_addr}, 64'h0);
        chk("rst_wb_data", {32'h0, mif.mult_wb_data}, 64'h0);
        chk("rst_hi", {32'h0, mif.mult_hi}, 64'h0);
        chk("rst_lo", {32'h0, mif.mult_lo}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Table vectors, isolated then back-to-back; expectations are hand-computed constants
        for (int i = 0; i < 10; i++) begin
            mif.mult_start_D = 1'b1;
            mif.stall = 1'b0;
            mif.mult_signed_D = tbl[i].sgn;
            mif.src_a_data_D = tbl[i].a;
            mif.src_b_data_D = tbl[i].b;
            mif.reg_dest_addr_mult = tbl[i].dest;
            sbq.push_back('{due: cyc + 5, addr: tbl[i].dest, prod: tbl[i].exp});
            @(posedge clk);
            #1;
            if (i < 5) idle(7);
        end
        idle(8);

        // Four consecutive launches, dests 1..4
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_0100, 5'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd2);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFE, 5'd3);
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0002, 5'd4);
        idle(8);

        // Held instruction under three stall cycles launches once on release
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0003, 5'd7);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0003, 5'd7);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0003, 5'd7);
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0003, 5'd7);
        idle(8);

        // Reset two cycles after launch discards the operation and clears HI/LO
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, 5'd5);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        hilo_cyc = -1;
        idle(10);
        @(negedge clk);
        chk("rst_mid_hi", {32'h0, mif.mult_hi}, 64'h0);
        chk("rst_mid_lo", {32'h0, mif.mult_lo}, 64'h0);
        @(posedge clk);
        #1;

        // Random traffic against the 64-bit reference model
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) b = 32'h0;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                  a, b, 5'($urandom_range(0, 31)));
        end

        idle(1);
        for (int i = 0; i < 50 && sbq.size() > 0; i++) idle(1);
        if (sbq.size() > 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain: got %0d outstanding results, want 0", sbq.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
